// File: rtl/pipe_regfile.sv
// ============================================================================
// pipe_regfile
//   Register file with a per-entry scoreboard ("pending") bit and a
//   self-clearing start-up sequence.
//
//   After reset the block walks every entry once (CLEAR state) and writes 0,
//   one entry per cycle, asserting init_busy.  It then enters READY, where
//   writes store data and retire the pending bit, and sb_set_en marks an
//   entry as having a write in flight.  Reads are combinational.
//
//   Parameters
//     DATA_W   : register width in bits
//     ADDR_W   : address width; NREGS = 2**ADDR_W entries
//     ZERO_REG : when 1, entry 0 reads 0, ignores writes, never pending
//
//   Ports
//     clk                        : single clock, rising edge
//     reset                      : synchronous, active-high
//     rg_wrt_en/addr/data        : write port
//     rg_rd_addr1/2              : read addresses
//     rg_rd_data1/2              : read data (0 while clearing)
//     rg_rd_pend1/2              : pending bit of each read address
//     sb_set_en/sb_set_addr      : mark an entry pending
//     init_busy                  : high while the clear sequence runs
//
//   Optional feature
//     REGFILE_BYPASS_EN : when defined, a write in READY is forwarded to a
//                         read port addressing the same entry in the same
//                         cycle.  Default build: reads show pre-edge state.
// ============================================================================
module pipe_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rg_wrt_en,
    input  logic [ADDR_W-1:0] rg_wrt_addr,
    input  logic [DATA_W-1:0] rg_wrt_data,
    input  logic [ADDR_W-1:0] rg_rd_addr1,
    input  logic [ADDR_W-1:0] rg_rd_addr2,
    output logic [DATA_W-1:0] rg_rd_data1,
    output logic [DATA_W-1:0] rg_rd_data2,
    input  logic              sb_set_en,
    input  logic [ADDR_W-1:0] sb_set_addr,
    output logic              rg_rd_pend1,
    output logic              rg_rd_pend2,
    output logic              init_busy
);

    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [NREGS-1:0]    pend_q, pend_d;
    logic [DATA_W-1:0]   mem_q [NREGS];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                wr_ok;
    logic                set_ok;
    logic                busy;

    // Requests to entry 0 are dropped outright when it is hardwired to zero.
    assign wr_ok  = rg_wrt_en && !((ZERO_REG != 0) && (rg_wrt_addr == '0));
    assign set_ok = sb_set_en && !((ZERO_REG != 0) && (sb_set_addr == '0));

    // Reset overrides the state combinationally so outputs go quiet at once.
    assign busy      = reset || (state_q == CLEAR);
    assign init_busy = busy;

    // ------------------------------------------------------------------
    // Control / next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        mem_we    = 1'b0;
        mem_waddr = rg_wrt_addr;
        mem_wdata = rg_wrt_data;

        case (state_q)
            CLEAR: begin
                // The single write port is borrowed to zero one entry/cycle.
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = '0;
                idx_d     = idx_q + ADDR_W'(1);
                pend_d    = '0;
                if (idx_q == ADDR_W'(NREGS - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                mem_we = wr_ok;
                if (wr_ok) begin
                    pend_d[rg_wrt_addr] = 1'b0;
                end
                // Applied after the write clear so a same-address set wins.
                if (set_ok) begin
                    pend_d[sb_set_addr] = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // Storage array has no reset; the CLEAR walk initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports (combinational)
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr_c;
        logic [DATA_W-1:0] data_c;
        logic              pend_c;

        assign addr_c = (gi == 0) ? rg_rd_addr1 : rg_rd_addr2;

        always_comb begin
            data_c = mem_q[addr_c];
            pend_c = pend_q[addr_c];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (addr_c == rg_wrt_addr)) begin
                data_c = rg_wrt_data;
                pend_c = set_ok && (sb_set_addr == addr_c);
            end
`endif
            if (busy || ((ZERO_REG != 0) && (addr_c == '0))) begin
                data_c = '0;
                pend_c = 1'b0;
            end
        end
    end

    assign rg_rd_data1 = g_rd[0].data_c;
    assign rg_rd_data2 = g_rd[1].data_c;
    assign rg_rd_pend1 = g_rd[0].pend_c;
    assign rg_rd_pend2 = g_rd[1].pend_c;

endmodule

// File: tb/tb_pipe_regfile.sv
// ============================================================================
// tb_pipe_regfile
//   Self-checking bench for pipe_regfile (DATA_W=32, ADDR_W=5, ZERO_REG=1).
//   Each read request pushes the expected port values (from a behavioural
//   model of the register file) onto a queue; the value is popped and
//   compared once the outputs have settled.  Honours REGFILE_BYPASS_EN.
// ============================================================================
module tb_pipe_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_addr;
    logic [31:0] rg_wrt_data;
    logic [4:0]  rg_rd_addr1, rg_rd_addr2;
    logic [31:0] rg_rd_data1, rg_rd_data2;
    logic        sb_set_en;
    logic [4:0]  sb_set_addr;
    logic        rg_rd_pend1, rg_rd_pend2;
    logic        init_busy;

    pipe_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .rg_wrt_en   (rg_wrt_en),
        .rg_wrt_addr (rg_wrt_addr),
        .rg_wrt_data (rg_wrt_data),
        .rg_rd_addr1 (rg_rd_addr1),
        .rg_rd_addr2 (rg_rd_addr2),
        .rg_rd_data1 (rg_rd_data1),
        .rg_rd_data2 (rg_rd_data2),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .rg_rd_pend1 (rg_rd_pend1),
        .rg_rd_pend2 (rg_rd_pend2),
        .init_busy   (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        p1;
        logic        p2;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;

    // Behavioural model
    logic [31:0] m_mem [32];
    logic        m_pend[32];
    bit          m_ready = 1'b0;
    int          m_idx   = 0;

    function automatic logic [31:0] model_data(input logic [4:0] a);
        if (reset || !m_ready || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (rg_wrt_en && a == rg_wrt_addr) return rg_wrt_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic model_pend(input logic [4:0] a);
        if (reset || !m_ready || a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (rg_wrt_en && a == rg_wrt_addr) return sb_set_en && (sb_set_addr == a);
`endif
        return m_pend[a];
    endfunction

    // Advance one clock edge, updating the model from the driven inputs.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_ready = 1'b0;
            m_idx   = 0;
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else if (!m_ready) begin
            m_mem[m_idx] = 32'h0;
            if (m_idx == 31) m_ready = 1'b1;
            m_idx++;
        end else begin
            if (rg_wrt_en && rg_wrt_addr != 5'd0) begin
                m_mem[rg_wrt_addr]  = rg_wrt_data;
                m_pend[rg_wrt_addr] = 1'b0;
            end
            if (sb_set_en && sb_set_addr != 5'd0) m_pend[sb_set_addr] = 1'b1;
        end
        #1;
    endtask

    // Drive read addresses (after write/set inputs) and queue the expectation.
    task automatic push_read(input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        rg_rd_addr1 = a1;
        rg_rd_addr2 = a2;
        e.d1 = model_data(a1);
        e.d2 = model_data(a2);
        e.p1 = model_pend(a1);
        e.p2 = model_pend(a2);
        sbq.push_back(e);
    endtask

    task automatic idle_inputs();
        rg_wrt_en   = 1'b0;
        sb_set_en   = 1'b0;
        rg_wrt_addr = 5'd0;
        rg_wrt_data = 32'h0;
        sb_set_addr = 5'd0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        exp_t e;
        int   busy_cnt;
        reset = 1'b1;
        rg_wrt_en = 1'b1; rg_wrt_addr = 5'd5; rg_wrt_data = 32'hFFFF_0000;
        sb_set_en = 1'b1; sb_set_addr = 5'd6;
        tick();
        push_read(5'd5, 5'd6);
        #1;
        e = sbq.pop_front();
        checks++;
        if ({rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2} !== {e.d1, e.p1, e.d2, e.p2}) begin
            failures++;
            $display("FAIL reset_outputs got d1=%h p1=%b d2=%h p2=%b exp d1=%h p1=%b d2=%h p2=%b",
                     rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2, e.d1, e.p1, e.d2, e.p2);
        end
        checks++;
        if (init_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy got %b exp 1", init_busy);
        end
        reset = 1'b0;
        busy_cnt = 0;
        // Writes/sets stay asserted throughout CLEAR and must be ignored.
        for (int c = 0; c < 100 && init_busy === 1'b1; c++) begin
            busy_cnt++;
            if (busy_cnt == 7) begin
                push_read(5'd5, 5'd6);
                #1;
                e = sbq.pop_front();
                checks++;
                if ({rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2} !== {e.d1, e.p1, e.d2, e.p2}) begin
                    failures++;
                    $display("FAIL clear_outputs got d1=%h p1=%b d2=%h p2=%b exp d1=%h p1=%b d2=%h p2=%b",
                             rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2, e.d1, e.p1, e.d2, e.p2);
                end
            end
            tick();
        end
        checks++;
        if (busy_cnt != 32) begin
            failures++;
            $display("FAIL busy_length got %0d cycles exp 32", busy_cnt);
        end
        $display("txn reset: init_busy high for %0d cycles", busy_cnt);
        idle_inputs();
        for (int a = 0; a < 32; a++) begin
            push_read(5'(a), 5'(31 - a));
            #1;
            e = sbq.pop_front();
            checks++;
            if ({rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2} !== {e.d1, e.p1, e.d2, e.p2}) begin
                failures++;
                $display("FAIL cleared_read a=%0d got d1=%h p1=%b d2=%h p2=%b exp d1=%h p1=%b d2=%h p2=%b",
                         a, rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2, e.d1, e.p1, e.d2, e.p2);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_read();
        exp_t e;
        logic [4:0] ra1 [3] = '{5'd5, 5'd0, 5'd5};
        logic [4:0] ra2 [3] = '{5'd5, 5'd0, 5'd0};
        for (int s = 0; s < 3; s++) begin
            idle_inputs();
            if (s == 0) begin
                rg_wrt_en = 1'b1; rg_wrt_addr = 5'd5; rg_wrt_data = 32'hDEAD_BEEF;
            end else if (s == 1) begin
                rg_wrt_en = 1'b1; rg_wrt_addr = 5'd0; rg_wrt_data = 32'h0000_1234;
                sb_set_en = 1'b1; sb_set_addr = 5'd0;
            end
            tick();
            idle_inputs();
            push_read(ra1[s], ra2[s]);
            #1;
            e = sbq.pop_front();
            checks++;
            if ({rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2} !== {e.d1, e.p1, e.d2, e.p2}) begin
                failures++;
                $display("FAIL write_read step=%0d got d1=%h p1=%b d2=%h p2=%b exp d1=%h p1=%b d2=%h p2=%b",
                         s, rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2, e.d1, e.p1, e.d2, e.p2);
            end
            $display("txn write_read step=%0d d1=%h d2=%h", s, rg_rd_data1, rg_rd_data2);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pending();
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            idle_inputs();
            case (s)
                0: begin sb_set_en = 1'b1; sb_set_addr = 5'd7; end
                1: begin rg_wrt_en = 1'b1; rg_wrt_addr = 5'd7; rg_wrt_data = 32'h55; end
                2: begin
                    rg_wrt_en = 1'b1; rg_wrt_addr = 5'd7; rg_wrt_data = 32'h55;
                    sb_set_en = 1'b1; sb_set_addr = 5'd7;
                end
                default: begin
                    rg_wrt_en = 1'b1; rg_wrt_addr = 5'd7; rg_wrt_data = 32'h99;
                    sb_set_en = 1'b1; sb_set_addr = 5'd7;
                end
            endcase
            tick();
            idle_inputs();
            push_read(5'd7, 5'd5);
            #1;
            e = sbq.pop_front();
            checks++;
            if ({rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2} !== {e.d1, e.p1, e.d2, e.p2}) begin
                failures++;
                $display("FAIL pending step=%0d got d1=%h p1=%b d2=%h p2=%b exp d1=%h p1=%b d2=%h p2=%b",
                         s, rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2, e.d1, e.p1, e.d2, e.p2);
            end
            $display("txn pending step=%0d r7=%h pend=%b", s, rg_rd_data1, rg_rd_pend1);
        end
    endtask

    // ------------------------------------------------------------------
    // Same-cycle write and read: forwarded or pre-edge depending on build.
    task automatic test_bypass();
        exp_t e;
        idle_inputs();
        rg_wrt_en = 1'b1; rg_wrt_addr = 5'd3; rg_wrt_data = 32'h1111_1111;
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        tick();
        for (int s = 0; s < 4; s++) begin
            idle_inputs();
            case (s)
                0: begin rg_wrt_en = 1'b1; rg_wrt_addr = 5'd3; rg_wrt_data = 32'hA5A5_A5A5; end
                1: begin end
                2: begin rg_wrt_en = 1'b1; rg_wrt_addr = 5'd9; rg_wrt_data = 32'h0000_0009; end
                default: begin
                    rg_wrt_en = 1'b1; rg_wrt_addr = 5'd9; rg_wrt_data = 32'h0000_0019;
                    sb_set_en = 1'b1; sb_set_addr = 5'd9;
                end
            endcase
            if (s < 2) push_read(5'd3, 5'd3);
            else       push_read(5'd9, 5'd3);
            #1;
            e = sbq.pop_front();
            checks++;
            if ({rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2} !== {e.d1, e.p1, e.d2, e.p2}) begin
                failures++;
                $display("FAIL bypass step=%0d got d1=%h p1=%b d2=%h p2=%b exp d1=%h p1=%b d2=%h p2=%b",
                         s, rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2, e.d1, e.p1, e.d2, e.p2);
            end
            $display("txn bypass step=%0d d1=%h p1=%b d2=%h", s, rg_rd_data1, rg_rd_pend1, rg_rd_data2);
            tick();
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        exp_t e;
        for (int n = 0; n < 48; n++) begin
            rg_wrt_en   = 1'($urandom_range(0, 1));
            rg_wrt_addr = 5'($urandom_range(0, 31));
            rg_wrt_data = $urandom;
            sb_set_en   = 1'($urandom_range(0, 1));
            sb_set_addr = (n % 4 == 0) ? rg_wrt_addr : 5'($urandom_range(0, 31));
            if (n % 3 == 0) push_read(rg_wrt_addr, 5'($urandom_range(0, 31)));
            else            push_read(5'($urandom_range(0, 31)), rg_wrt_addr);
            #1;
            e = sbq.pop_front();
            checks++;
            if ({rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2} !== {e.d1, e.p1, e.d2, e.p2}) begin
                failures++;
                $display("FAIL b2b n=%0d a1=%0d a2=%0d got d1=%h p1=%b d2=%h p2=%b exp d1=%h p1=%b d2=%h p2=%b",
                         n, rg_rd_addr1, rg_rd_addr2, rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2,
                         e.d1, e.p1, e.d2, e.p2);
            end
            $display("txn b2b n=%0d we=%b wa=%0d set=%b sa=%0d a1=%0d d1=%h a2=%0d d2=%h",
                     n, rg_wrt_en, rg_wrt_addr, sb_set_en, sb_set_addr,
                     rg_rd_addr1, rg_rd_data1, rg_rd_addr2, rg_rd_data2);
            tick();
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midclear();
        exp_t e;
        int   busy_cnt;
        // Make sure there is non-zero, pending state to be wiped.
        idle_inputs();
        rg_wrt_en = 1'b1; rg_wrt_addr = 5'd5; rg_wrt_data = 32'hCAFE_F00D;
        sb_set_en = 1'b1; sb_set_addr = 5'd7;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rg_wrt_en = 1'b1; rg_wrt_addr = 5'd3; rg_wrt_data = 32'h3333_3333;
        sb_set_en = 1'b1; sb_set_addr = 5'd3;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 100 && init_busy === 1'b1; c++) begin
            busy_cnt++;
            tick();
        end
        checks++;
        if (busy_cnt != 32) begin
            failures++;
            $display("FAIL midclear_busy_length got %0d cycles exp 32", busy_cnt);
        end
        $display("txn midclear: init_busy high for %0d cycles", busy_cnt);
        idle_inputs();
        for (int s = 0; s < 3; s++) begin
            if (s == 0)      push_read(5'd3, 5'd5);
            else if (s == 1) push_read(5'd7, 5'd9);
            else             push_read(5'd12, 5'd31);
            #1;
            e = sbq.pop_front();
            checks++;
            if ({rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2} !== {e.d1, e.p1, e.d2, e.p2}) begin
                failures++;
                $display("FAIL midclear_read step=%0d got d1=%h p1=%b d2=%h p2=%b exp d1=%h p1=%b d2=%h p2=%b",
                         s, rg_rd_data1, rg_rd_pend1, rg_rd_data2, rg_rd_pend2, e.d1, e.p1, e.d2, e.p2);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        reset       = 1'b1;
        rg_rd_addr1 = 5'd0;
        rg_rd_addr2 = 5'd0;
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_pending();
        test_bypass();
        test_back_to_back();
        test_reset_midclear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
